// File: rtl/peasant_mult_seq.sv
// Sequential shift-and-add (Russian peasant) unsigned multiplier.
// One RUN cycle per significant bit of x; a zero multiplier takes a single RUN cycle.
module peasant_mult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xr;
    logic [PW-1:0]    yr;
    logic [PW-1:0]    acc;

    logic [PW-1:0]    acc_nxt_c;
    logic             last_c;

    // Accumulate on an odd multiplier; finish once no set bits remain above bit 0.
    always_comb begin
        acc_nxt_c = xr[0] ? acc + yr : acc;
        last_c    = ((xr >> 1) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            xr      <= '0;
            yr      <= '0;
            acc     <= '0;
            product <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x;
                        yr    <= PW'(y);
                        acc   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_nxt_c;
                    xr  <= xr >> 1;
                    yr  <= yr << 1;
                    if (last_c) begin
                        product <= acc_nxt_c;
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peasant_mult_seq.sv
// Directed and randomized checks of peasant_mult_seq with an expected-result queue.
module tb_peasant_mult_seq;

    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic             ready;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    typedef struct {
        logic [63:0] p;
        int unsigned n;
    } exp_t;

    exp_t        sb[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    peasant_mult_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total += 1;
        assert (obs === exp) passed += 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Number of RUN cycles: index of highest set bit plus one, or one for zero.
    function automatic int unsigned n_ref(input logic [W-1:0] a);
        int unsigned n = 1;
        for (int i = 0; i < int'(W); i++)
            if (a[i]) n = i + 1;
        return n;
    endfunction

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp_p, input int unsigned exp_n);
        exp_t e;
        x     = a;
        y     = b;
        start = 1'b1;
        e.p   = exp_p;
        e.n   = exp_n;
        sb.push_back(e);
    endtask

    // Called at the first RUN negedge; returns at the DONE negedge.
    task automatic finish_op(input string tag);
        int unsigned cyc = 0;
        exp_t        e;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            x     = $urandom;
            y     = $urandom;
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"},  64'(done),  64'd1);
        chk({tag, "_ready"}, 64'(ready), 64'd0);
        e = sb.pop_front();
        chk({tag, "_product"}, product,  e.p);
        chk({tag, "_n"},       64'(cyc), 64'(e.n));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [63:0] exp_p, input int unsigned exp_n, input string tag);
        chk({tag, "_ready_in"}, 64'(ready), 64'd1);
        launch(a, b, exp_p, exp_n);
        @(negedge clk);
        finish_op(tag);
        @(negedge clk);
        chk({tag, "_pulse"},     64'(done),  64'd0);
        chk({tag, "_ready_out"}, 64'(ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        #1;
        chk("rst0_ready",   64'(ready), 64'd1);
        chk("rst0_busy",    64'(busy),  64'd0);
        chk("rst0_done",    64'(done),  64'd0);
        chk("rst0_product", product,    64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op(32'd13, 32'd11, 64'd143, 4, "x13");
        op(32'd0, 32'hDEADBEEF, 64'd0, 1, "x0");
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32, "xmax");

        // Start held through DONE is ignored there and accepted on the next IDLE cycle.
        chk("hold_ready_in", 64'(ready), 64'd1);
        launch(32'd1, 32'd7, 64'd7, 1);
        @(negedge clk);
        finish_op("hold1");
        launch(32'd3, 32'd5, 64'd15, 2);
        @(negedge clk);
        chk("hold_idle_ready", 64'(ready), 64'd1);
        chk("hold_idle_busy",  64'(busy),  64'd0);
        chk("hold_idle_prod",  product,    64'd7);
        @(negedge clk);
        chk("hold_accept_busy", 64'(busy), 64'd1);
        finish_op("hold2");
        @(negedge clk);
        chk("hold2_ready_out", 64'(ready), 64'd1);

        // Abort a long operation with reset in its tenth RUN cycle.
        chk("abort_ready_in", 64'(ready), 64'd1);
        x     = 32'h80000000;
        y     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_ready",   64'(ready), 64'd1);
        chk("abort_busy0",   64'(busy),  64'd0);
        chk("abort_done",    64'(done),  64'd0);
        chk("abort_product", product,    64'd0);
        @(negedge clk);
        chk("abort_hold_done", 64'(done), 64'd0);
        chk("abort_hold_prod", product,   64'd0);
        rst = 1'b0;
        op(32'd6, 32'd7, 64'd42, 3, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom) >> $urandom_range(0, 31);
            b = W'($urandom);
            op(a, b, 64'(a) * 64'(b), n_ref(a), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
